// File: rtl/instr_fetch_sequencer_pkg.sv
// Shared encodings for the variable-length 6502 fetch sequencer:
// FSM states, recognised opcodes and the opcode length decode.
package fetch_pkg;

  typedef enum logic [2:0] {
    FETCH_OP = 3'd0,
    FETCH_LO = 3'd1,
    FETCH_HI = 3'd2,
    ISSUE    = 3'd3,
    HALT     = 3'd4
  } state_t;

  localparam logic [7:0] OP_BRK     = 8'h00;
  localparam logic [7:0] OP_NOP     = 8'hEA;
  localparam logic [7:0] OP_RTS     = 8'h60;
  localparam logic [7:0] OP_LDA_IMM = 8'hA9;
  localparam logic [7:0] OP_LDA_ZP  = 8'hA5;
  localparam logic [7:0] OP_LDA_ZPX = 8'hB5;
  localparam logic [7:0] OP_STA_ZP  = 8'h85;
  localparam logic [7:0] OP_LDA_ABS = 8'hAD;
  localparam logic [7:0] OP_STA_ABS = 8'h8D;
  localparam logic [7:0] OP_JMP_ABS = 8'h4C;
  localparam logic [7:0] OP_JSR     = 8'h20;

  // Returns {illegal, len[1:0]}; unknown opcodes are one byte long and illegal.
  function automatic logic [2:0] opcode_len(input logic [7:0] op);
    case (op)
      OP_BRK, OP_NOP, OP_RTS:                          return 3'b001;
      OP_LDA_IMM, OP_LDA_ZP, OP_LDA_ZPX, OP_STA_ZP:    return 3'b010;
      OP_LDA_ABS, OP_STA_ABS, OP_JMP_ABS, OP_JSR:      return 3'b011;
      default:                                         return 3'b101;
    endcase
  endfunction

endpackage

// File: rtl/instr_fetch_sequencer_if.sv
// Memory fetch port, instruction issue handshake and PC redirect bundle.
// master = sequencer side, slave = memory / execute side.
interface instr_fetch_sequencer_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 16
) ();

  logic                  mem_req;
  logic [ADDR_W-1:0]     mem_addr;
  logic                  mem_ready;
  logic [DATA_W-1:0]     mem_rdata;

  logic                  instr_valid;
  logic                  instr_ready;
  logic [DATA_W-1:0]     opcode;
  logic [2*DATA_W-1:0]   operand;
  logic [1:0]            instr_len;
  logic [ADDR_W-1:0]     instr_pc;
  logic                  illegal;

  logic                  redirect_valid;
  logic [ADDR_W-1:0]     redirect_pc;

  modport master (
    output mem_req, mem_addr, instr_valid, opcode, operand, instr_len, instr_pc, illegal,
    input  mem_ready, mem_rdata, instr_ready, redirect_valid, redirect_pc
  );

  modport slave (
    input  mem_req, mem_addr, instr_valid, opcode, operand, instr_len, instr_pc, illegal,
    output mem_ready, mem_rdata, instr_ready, redirect_valid, redirect_pc
  );

endinterface

// File: rtl/instr_fetch_sequencer.sv
// Fetches 1..3 byte 6502 instructions byte by byte, assembles opcode/operand/PC
// and issues them over a valid/ready handshake; halts on illegal opcodes.
module instr_fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int                DATA_W   = 8,
  parameter int                ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                      clk,
  input  logic                      reset,
  instr_fetch_sequencer_if.master   bus,
  output logic [2:0]                state,
  output logic [2:0]                next
);

  state_t                state_q, state_d;
  logic [ADDR_W-1:0]     pc;
  logic [DATA_W-1:0]     opcode_q;
  logic [2*DATA_W-1:0]   operand_q;
  logic [1:0]            len_q;
  logic [ADDR_W-1:0]     ipc_q;
  logic                  ill_q;

  logic                  mem_req;
  logic                  instr_valid;
  logic                  redirect;
  logic                  accept;
  logic [2:0]            dec;

  // Opcodes wider than a 6502 byte can never match the table.
  always_comb begin
    dec = opcode_len(bus.mem_rdata[7:0]);
    if (DATA_W > 8 && (bus.mem_rdata >> 8) != '0) dec = 3'b101;
  end

  assign redirect = bus.redirect_valid && (state_q != HALT);
  assign accept   = mem_req && bus.mem_ready && !bus.redirect_valid;

  always_comb begin
    state_d     = state_q;
    mem_req     = 1'b0;
    instr_valid = 1'b0;
    case (state_q)
      FETCH_OP: begin
        mem_req = 1'b1;
        if (bus.mem_ready) state_d = (dec[1:0] == 2'd1) ? ISSUE : FETCH_LO;
      end
      FETCH_LO: begin
        mem_req = 1'b1;
        if (bus.mem_ready) state_d = (len_q == 2'd2) ? ISSUE : FETCH_HI;
      end
      FETCH_HI: begin
        mem_req = 1'b1;
        if (bus.mem_ready) state_d = ISSUE;
      end
      ISSUE: begin
        instr_valid = 1'b1;
        if (bus.instr_ready) state_d = ill_q ? HALT : FETCH_OP;
      end
      HALT:    state_d = HALT;
      default: state_d = FETCH_OP;
    endcase
    // A redirect wins over both byte capture and the issue handshake outcome.
    if (redirect) state_d = FETCH_OP;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= FETCH_OP;
      pc        <= RESET_PC;
      opcode_q  <= '0;
      operand_q <= '0;
      len_q     <= 2'd1;
      ipc_q     <= RESET_PC;
      ill_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      if (redirect) begin
        pc <= bus.redirect_pc;
      end else if (accept) begin
        pc <= pc + ADDR_W'(1);
        case (state_q)
          FETCH_OP: begin
            opcode_q  <= bus.mem_rdata;
            operand_q <= '0;
            ipc_q     <= pc;
            len_q     <= dec[1:0];
            ill_q     <= dec[2];
          end
          FETCH_LO: operand_q[DATA_W-1:0]        <= bus.mem_rdata;
          FETCH_HI: operand_q[2*DATA_W-1:DATA_W] <= bus.mem_rdata;
          default: ;
        endcase
      end
    end
  end

  assign bus.mem_req     = mem_req;
  assign bus.mem_addr    = pc;
  assign bus.instr_valid = instr_valid;
  assign bus.opcode      = opcode_q;
  assign bus.operand     = operand_q;
  assign bus.instr_len   = len_q;
  assign bus.instr_pc    = ipc_q;
  assign bus.illegal     = ill_q;
  assign state           = state_q;
  assign next            = state_d;

endmodule
